// File: rtl/rdata_src_arbiter.sv
// rdata_src_arbiter
//   Shares the read-data-channel subordinate (rdata_chan_subo) between NSRC memory-side
//   sources. Each source raises a level request carrying one DW-bit line and its AXI id.
//   One source is granted, and its line and id are latched and held toward the subordinate
//   until finish_rdata_s arrives. The winner then receives a one-cycle src_done pulse.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   src_valid[i]     level request from source i, held until its own src_done
//   src_id/src_data  per-source id/line, slice i = [i*IDW +: IDW] / [i*DW +: DW]
//   src_done[i]      one-cycle pulse to the granted source once its line is fully sent
//   rdata_s_valid    level request toward rdata_chan_subo
//   rdata_s_id/data  latched id/line of the granted source, stable for the whole burst
//   finish_rdata_s   one-cycle pulse from rdata_chan_subo: last beat accepted
//   grant_idx        index of the current/last granted source
//   err_tmo          sticky watchdog flag, set when a burst stays busy too long
//
// All outputs are registered; nothing from src_* or finish_rdata_s reaches an output
// combinationally.

module rdata_src_arbiter #(
   parameter int NSRC       = 2,
   parameter int IDW        = 4,
   parameter int DW         = 128,
   parameter int FIXED_PRIO = 0,
   parameter int TMO_W      = 10,
   parameter int TMO_EN     = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      src_valid,
   input  logic [NSRC*IDW-1:0]  src_id,
   input  logic [NSRC*DW-1:0]   src_data,
   output logic [NSRC-1:0]      src_done,
   output logic                 rdata_s_valid,
   output logic [IDW-1:0]       rdata_s_id,
   output logic [DW-1:0]        rdata_s_data,
   input  logic                 finish_rdata_s,
   output logic [1:0]           grant_idx,
   output logic                 err_tmo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // Round-robin search start: one past the last winner, 0 after reset.
   logic [1:0]      rr_ptr;
   logic [1:0]      rr_nxt;

   logic [1:0]      win_idx;
   logic            win_vld;
   logic [NSRC-1:0] done_vec;

   //------------------------------------------------------------------
   // Winner selection.
   // Offsets are scanned from the farthest to the nearest so that the
   // last assignment made is the first requester found from the search
   // start; this avoids a loop break. Fixed priority simply starts at 0.
   //------------------------------------------------------------------
   always_comb begin
      int start;
      int idx;
      win_idx = 2'd0;
      win_vld = 1'b0;
      start   = (FIXED_PRIO != 0) ? 0 : int'(rr_ptr);
      idx     = 0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         idx = start + k;
         if (idx >= NSRC) begin
            idx = idx - NSRC;
         end
         if (src_valid[idx]) begin
            win_idx = 2'(idx);
            win_vld = 1'b1;
         end
      end
   end

   // Pointer that will be in force after a grant to win_idx (modulo NSRC).
   always_comb begin
      rr_nxt = 2'd0;
      if (int'(win_idx) != NSRC - 1) begin
         rr_nxt = win_idx + 2'd1;
      end
   end

   // One-hot done vector addressed by the held grant index.
   always_comb begin
      done_vec = '0;
      for (int i = 0; i < NSRC; i++) begin
         done_vec[i] = (grant_idx == 2'(i));
      end
   end

   //------------------------------------------------------------------
   // FSM
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = win_vld ? BUSY : IDLE;
         BUSY:    state_nxt = finish_rdata_s ? DONE : BUSY;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // Registered outputs and grant bookkeeping.
   // The line/id are captured once at grant time and never touched again
   // until the next grant, so source-side changes during a burst cannot
   // leak through. finish_rdata_s is only honoured in BUSY.
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_s_valid <= 1'b0;
         rdata_s_id    <= '0;
         rdata_s_data  <= '0;
         src_done      <= '0;
         grant_idx     <= 2'd0;
         rr_ptr        <= 2'd0;
      end else begin
         src_done <= '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  rdata_s_valid <= 1'b1;
                  rdata_s_id    <= src_id[int'(win_idx)*IDW +: IDW];
                  rdata_s_data  <= src_data[int'(win_idx)*DW +: DW];
                  grant_idx     <= win_idx;
                  if (FIXED_PRIO == 0) begin
                     rr_ptr <= rr_nxt;
                  end
               end
            end
            BUSY: begin
               if (finish_rdata_s) begin
                  rdata_s_valid <= 1'b0;
                  src_done      <= done_vec;
               end
            end
            default: begin
               rdata_s_valid <= 1'b0;
            end
         endcase
      end
   end

   //------------------------------------------------------------------
   // Busy watchdog.
   // wd_cnt holds the number of completed BUSY cycles of the current
   // burst and saturates at all-ones; err_tmo is raised on the same edge
   // the count reaches all-ones. It only reports: the burst is not aborted.
   //------------------------------------------------------------------
   if (TMO_EN != 0) begin : g_wdog
      localparam logic [TMO_W-1:0] WD_ONE = 1;
      localparam logic [TMO_W-1:0] WD_MAX = '1;
      localparam logic [TMO_W-1:0] WD_PRE = WD_MAX - WD_ONE;

      logic [TMO_W-1:0] wd_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wd_cnt  <= '0;
            err_tmo <= 1'b0;
         end else if (state == IDLE && win_vld) begin
            wd_cnt <= '0;
         end else if (state == BUSY && wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + WD_ONE;
            if (wd_cnt == WD_PRE) begin
               err_tmo <= 1'b1;
            end
         end
      end
   end else begin : g_no_wdog
      assign err_tmo = 1'b0;
   end

endmodule

// File: tb/tb_rdata_src_arbiter.sv
// tb_rdata_src_arbiter
//   Bench for rdata_src_arbiter. Instance A: 3 sources, round-robin, 4-bit watchdog.
//   Instance B: 2 sources, fixed priority. Inputs are driven and outputs sampled on the
//   falling clock edge. Expected winners come from a list-scan model of pending requests.

module tb_rdata_src_arbiter;

   localparam int NA  = 3;
   localparam int NB  = 2;
   localparam int IDW = 4;
   localparam int DW  = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic [NA-1:0]      a_valid = '0;
   logic [NA*IDW-1:0]  a_id = '0;
   logic [NA*DW-1:0]   a_data = '0;
   logic [NA-1:0]      a_done;
   logic               a_sv;
   logic [IDW-1:0]     a_sid;
   logic [DW-1:0]      a_sdata;
   logic               a_fin = 1'b0;
   logic [1:0]         a_gidx;
   logic               a_err;

   // instance B
   logic [NB-1:0]      b_valid = '0;
   logic [NB*IDW-1:0]  b_id = '0;
   logic [NB*DW-1:0]   b_data = '0;
   logic [NB-1:0]      b_done;
   logic               b_sv;
   logic [IDW-1:0]     b_sid;
   logic [DW-1:0]      b_sdata;
   logic               b_fin = 1'b0;
   logic [1:0]         b_gidx;
   logic               b_err;

   rdata_src_arbiter #(.NSRC(NA), .IDW(IDW), .DW(DW), .FIXED_PRIO(0), .TMO_W(4), .TMO_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .src_valid(a_valid), .src_id(a_id), .src_data(a_data),
      .src_done(a_done), .rdata_s_valid(a_sv), .rdata_s_id(a_sid), .rdata_s_data(a_sdata),
      .finish_rdata_s(a_fin), .grant_idx(a_gidx), .err_tmo(a_err));

   rdata_src_arbiter #(.NSRC(NB), .IDW(IDW), .DW(DW), .FIXED_PRIO(1), .TMO_W(10), .TMO_EN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .src_valid(b_valid), .src_id(b_id), .src_data(b_data),
      .src_done(b_done), .rdata_s_valid(b_sv), .rdata_s_id(b_sid), .rdata_s_data(b_sdata),
      .finish_rdata_s(b_fin), .grant_idx(b_gidx), .err_tmo(b_err));

   int n_cmp = 0;
   int n_bad = 0;

   // reference model for instance A: pending set and round-robin start
   bit a_pend [NA];
   int a_ptr = 0;

   typedef struct {
      logic [NA-1:0] mask;
      int            exp_w;
      int            burst;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // first pending source scanning from a_ptr, wrapping modulo NA
   function automatic int a_pick();
      for (int off = 0; off < NA; off++) begin
         if (a_pend[(a_ptr + off) % NA]) return (a_ptr + off) % NA;
      end
      return -1;
   endfunction

   // One transaction on A, entered at the falling edge where the requests were driven.
   task automatic a_txn(input int exp_w, input int burst, input bit toggle);
      logic [IDW-1:0] eid;
      logic [DW-1:0]  edata;
      logic [DW-1:0]  oh;
      int waited;
      eid   = a_id[exp_w*IDW +: IDW];
      edata = a_data[exp_w*DW +: DW];
      oh    = '0;
      oh[exp_w] = 1'b1;
      @(negedge clk);
      chk("grant_latency", DW'(a_sv), DW'(1));
      waited = 0;
      while (!a_sv && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!a_sv) begin
         n_cmp++;
         n_bad++;
         $display("FAIL grant_timeout: got rdata_s_valid 0 want 1 within 10 cycles");
         return;
      end
      chk("grant_idx", DW'(a_gidx), DW'(exp_w));
      chk("grant_id", DW'(a_sid), DW'(eid));
      chk("grant_data", a_sdata, edata);
      for (int b = 0; b < burst; b++) begin
         @(negedge clk);
         chk("busy_valid", DW'(a_sv), DW'(1));
         chk("busy_id_hold", DW'(a_sid), DW'(eid));
         chk("busy_data_hold", a_sdata, edata);
         chk("busy_no_done", DW'(a_done), DW'(0));
         if (toggle) begin
            a_id[exp_w*IDW +: IDW]  = 4'($urandom);
            a_data[exp_w*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      a_fin = 1'b1;
      @(negedge clk);
      a_fin = 1'b0;
      chk("done_onehot", DW'(a_done), oh);
      chk("done_valid_low", DW'(a_sv), DW'(0));
      a_valid[exp_w] = 1'b0;
      a_pend[exp_w]  = 1'b0;
      a_ptr          = (exp_w + 1) % NA;
      @(negedge clk);
      chk("done_single_cycle", DW'(a_done), DW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w;
      int any;

      vt[0] = '{3'b001, 0, 0};
      vt[1] = '{3'b111, 1, 1};
      vt[2] = '{3'b111, 2, 3};
      vt[3] = '{3'b110, 1, 0};
      vt[4] = '{3'b011, 0, 2};
      vt[5] = '{3'b101, 2, 5};
      vt[6] = '{3'b100, 2, 1};
      vt[7] = '{3'b011, 0, 0};

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_valid", DW'(a_sv), DW'(0));
      chk("rst_id", DW'(a_sid), DW'(0));
      chk("rst_data", a_sdata, DW'(0));
      chk("rst_done", DW'(a_done), DW'(0));
      chk("rst_gidx", DW'(a_gidx), DW'(0));
      chk("rst_err", DW'(a_err), DW'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_valid", DW'(a_sv), DW'(0));

      // finish outside BUSY is ignored
      a_fin = 1'b1;
      @(negedge clk);
      a_fin = 1'b0;
      chk("stray_finish_done", DW'(a_done), DW'(0));
      @(negedge clk);
      chk("stray_finish_valid", DW'(a_sv), DW'(0));
      chk("stray_finish_done2", DW'(a_done), DW'(0));

      // table: round-robin decisions from reset
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < NA; s++) begin
            a_id[s*IDW +: IDW] = 4'(i*3 + s + 1);
            a_data[s*DW +: DW] = {4{32'(i*256 + s)}};
         end
         a_valid = vt[i].mask;
         a_txn(vt[i].exp_w, vt[i].burst, 1'b0);
         a_valid = '0;
      end

      // single request with known id/line
      a_id[0 +: IDW]  = 4'h5;
      a_data[0 +: DW] = 128'h100f0e0d_0c0b0a09_08070605_04030201;
      a_valid = 3'b001;
      a_txn(0, 2, 1'b0);
      chk("t2_id", DW'(a_sid), DW'(4'h5));
      chk("t2_data", a_sdata, 128'h100f0e0d_0c0b0a09_08070605_04030201);

      // move the pointer back to 0, then two sources contend continuously
      a_valid = 3'b100;
      a_txn(2, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         a_valid = 3'b011;
         a_txn(k % 2, 1 + (k % 3), 1'b0);
      end
      a_valid = '0;

      // source line/id churn during a burst must not reach the outputs
      a_valid = 3'b001;
      a_txn(0, 6, 1'b1);

      // randomized traffic against the pending-set model
      for (int s = 0; s < NA; s++) a_pend[s] = 1'b0;
      a_valid = '0;
      for (int r = 0; r < 60; r++) begin
         any = 0;
         for (int s = 0; s < NA; s++) begin
            if (!a_pend[s] && $urandom_range(1, 0) == 1) begin
               a_pend[s] = 1'b1;
               a_valid[s] = 1'b1;
               a_id[s*IDW +: IDW] = 4'($urandom);
               a_data[s*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (a_pend[s]) any = 1;
         end
         if (any == 0) begin
            w = $urandom_range(NA - 1, 0);
            a_pend[w] = 1'b1;
            a_valid[w] = 1'b1;
            a_id[w*IDW +: IDW] = 4'($urandom);
            a_data[w*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
         end
         w = a_pick();
         a_txn(w, $urandom_range(5, 0), $urandom_range(1, 0) == 1);
      end
      for (int s = 0; s < NA; s++) begin
         a_pend[s] = 1'b0;
      end
      a_valid = '0;
      @(negedge clk);
      chk("no_tmo_short_bursts", DW'(a_err), DW'(0));

      // fixed priority instance: source 0 always wins while requesting
      b_id = {4'h9, 4'h3};
      b_data = {{4{32'hbbbb_0001}}, {4{32'haaaa_0000}}};
      for (int k = 0; k < 4; k++) begin
         b_valid = 2'b11;
         @(negedge clk);
         chk("fp_valid", DW'(b_sv), DW'(1));
         chk("fp_gidx", DW'(b_gidx), DW'(0));
         chk("fp_id", DW'(b_sid), DW'(4'h3));
         @(negedge clk);
         b_fin = 1'b1;
         @(negedge clk);
         b_fin = 1'b0;
         chk("fp_done", DW'(b_done), DW'(2'b01));
         b_valid[0] = 1'b0;
         @(negedge clk);
         chk("fp_done_clear", DW'(b_done), DW'(0));
      end
      b_valid = 2'b10;
      @(negedge clk);
      chk("fp_gidx1", DW'(b_gidx), DW'(1));
      chk("fp_id1", DW'(b_sid), DW'(4'h9));
      b_fin = 1'b1;
      @(negedge clk);
      b_fin = 1'b0;
      chk("fp_done1", DW'(b_done), DW'(2'b10));
      b_valid = '0;

      // watchdog: finish withheld for 20 BUSY cycles
      a_valid = 3'b001;
      @(negedge clk);
      chk("wd_busy", DW'(a_sv), DW'(1));
      chk("wd_err_start", DW'(a_err), DW'(0));
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 14) chk("wd_err_after14", DW'(a_err), DW'(0));
         if (k == 15) chk("wd_err_after15", DW'(a_err), DW'(1));
         if (k == 20) chk("wd_still_busy", DW'(a_sv), DW'(1));
      end
      a_fin = 1'b1;
      @(negedge clk);
      a_fin = 1'b0;
      chk("wd_done", DW'(a_done), DW'(3'b001));
      a_valid = '0;
      a_ptr = 1;
      repeat (3) @(negedge clk);
      chk("wd_idle", DW'(a_sv), DW'(0));
      chk("wd_err_sticky", DW'(a_err), DW'(1));

      // asynchronous reset in the middle of a burst
      a_id[1*IDW +: IDW] = 4'hc;
      a_data[1*DW +: DW] = {4{32'hdead_beef}};
      a_valid = 3'b010;
      @(negedge clk);
      chk("t1_busy", DW'(a_sv), DW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_valid", DW'(a_sv), DW'(0));
      chk("t1_id", DW'(a_sid), DW'(0));
      chk("t1_data", a_sdata, DW'(0));
      chk("t1_done", DW'(a_done), DW'(0));
      chk("t1_gidx", DW'(a_gidx), DW'(0));
      chk("t1_err", DW'(a_err), DW'(0));
      a_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t1_post_valid", DW'(a_sv), DW'(0));
         chk("t1_post_done", DW'(a_done), DW'(0));
      end
      // pointer restarts at 0 after reset
      a_ptr = 0;
      a_valid = 3'b011;
      a_txn(0, 1, 1'b0);
      a_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
